// File: rtl/rc4_prga_engine.sv
// rc4_prga_engine: RC4 PRGA/decrypt engine driving S-box RAM, encrypted ROM and decrypted RAM.
// Optional PLAINTEXT_CHECK_EN aborts on the first byte outside 'a'..'z' or space (key-search early abort).
module rc4_prga_engine #(
    parameter int DATA_W  = 8,
    parameter int MSG_LEN = 32,
    parameter int RD_LAT  = 2,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    output logic              s_wen_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    output logic [MSG_AW-1:0] enc_addr_o,
    input  logic [DATA_W-1:0] enc_rdata_i,
    output logic [MSG_AW-1:0] dec_addr_o,
    output logic [DATA_W-1:0] dec_wdata_o,
    output logic              dec_wen_o,
    output logic              valid_o
);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [3:0] {IDLE, INC_I, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_F, RD_ENC, WR_DEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d;
    logic [MSG_AW-1:0] k_q, k_d, enc_addr_q, enc_addr_d, dec_addr_q, dec_addr_d;
    logic [DATA_W-1:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d, dec_wdata_q, dec_wdata_d;
    logic              busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic              s_wen_q, s_wen_d, dec_wen_q, dec_wen_d;
    logic              ok, hit, hit1;

    always_comb begin
`ifdef PLAINTEXT_CHECK_EN
        ok = (dec_wdata_q >= DATA_W'(8'h61) && dec_wdata_q <= DATA_W'(8'h7A)) || dec_wdata_q == DATA_W'(8'h20);
`else
        ok = 1'b1;
`endif
        // RD_SJ and RD_F spend their first cycle forming the address, so they sample one cycle later
        hit  = cnt_q == CW'(RD_LAT - 1);
        hit1 = cnt_q == CW'(RD_LAT);
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        si_d        = si_q;
        sj_d        = sj_q;
        f_d         = f_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_wen_d     = 1'b0;
        enc_addr_d  = enc_addr_q;
        dec_addr_d  = dec_addr_q;
        dec_wdata_d = dec_wdata_q;
        dec_wen_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        case (state_q)
            IDLE: if (start_i) begin
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                valid_d = 1'b0;
                busy_d  = 1'b1;
                state_d = INC_I;
            end
            INC_I: begin
                i_d      = i_q + 1'b1;
                s_addr_d = i_q + 1'b1;
                state_d  = RD_SI;
            end
            RD_SI: if (hit) begin
                si_d    = s_rdata_i;
                state_d = RD_SJ;
            end
            RD_SJ: begin
                if (cnt_q == '0) begin
                    j_d      = j_q + si_q;
                    s_addr_d = j_q + si_q;
                end
                if (hit1) begin
                    sj_d      = s_rdata_i;
                    s_addr_d  = i_q;
                    s_wdata_d = s_rdata_i;
                    s_wen_d   = 1'b1;
                    state_d   = WR_SI;
                end
            end
            WR_SI: begin
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_wen_d   = 1'b1;
                state_d   = WR_SJ;
            end
            WR_SJ: state_d = RD_F;
            RD_F: begin
                if (cnt_q == '0) s_addr_d = si_q + sj_q;
                if (hit1) begin
                    f_d        = s_rdata_i;
                    enc_addr_d = k_q;
                    state_d    = RD_ENC;
                end
            end
            RD_ENC: if (hit) begin
                dec_addr_d  = k_q;
                dec_wdata_d = f_q ^ enc_rdata_i;
                dec_wen_d   = 1'b1;
                state_d     = WR_DEC;
            end
            WR_DEC: if (k_q == MSG_AW'(MSG_LEN - 1) || !ok) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                valid_d = ok;
                state_d = DONE;
            end else begin
                k_d     = k_q + 1'b1;
                state_d = INC_I;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            f_q         <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wen_q     <= 1'b0;
            enc_addr_q  <= '0;
            dec_addr_q  <= '0;
            dec_wdata_q <= '0;
            dec_wen_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            f_q         <= f_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wen_q     <= s_wen_d;
            enc_addr_q  <= enc_addr_d;
            dec_addr_q  <= dec_addr_d;
            dec_wdata_q <= dec_wdata_d;
            dec_wen_q   <= dec_wen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign valid_o     = valid_q;
    assign s_addr_o    = s_addr_q;
    assign s_wdata_o   = s_wdata_q;
    assign s_wen_o     = s_wen_q;
    assign enc_addr_o  = enc_addr_q;
    assign dec_addr_o  = dec_addr_q;
    assign dec_wdata_o = dec_wdata_q;
    assign dec_wen_o   = dec_wen_q;
endmodule

// File: tb/tb_rc4_prga_engine.sv
// tb_rc4_prga_engine: known RC4 vectors, randomized runs against a plain RC4 model, reset and re-start corners.
module tb_rc4_prga_engine;
    localparam int DW = 8, ML = 9, RL = 2, AW = 4, BC = 6 + 4 * RL;
`ifdef PLAINTEXT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0, reset_n, start_i, ld;
    logic busy_o, done_o, s_wen_o, dec_wen_o, valid_o;
    logic [DW-1:0] s_addr_o, s_wdata_o, s_rdata_i, enc_rdata_i, dec_wdata_o;
    logic [AW-1:0] enc_addr_o, dec_addr_o;

    rc4_prga_engine #(.DATA_W(DW), .MSG_LEN(ML), .RD_LAT(RL), .MSG_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wen_o(s_wen_o), .s_rdata_i(s_rdata_i),
        .enc_addr_o(enc_addr_o), .enc_rdata_i(enc_rdata_i), .dec_addr_o(dec_addr_o),
        .dec_wdata_o(dec_wdata_o), .dec_wen_o(dec_wen_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    logic [7:0] smem [256], s_init [256], m_s [256];
    logic [7:0] enc_mem [16], dec_mem [16], m_dec [16];
    logic [7:0] s_pipe [RL], e_pipe [RL];
    int nwr, ndone, nbusy, novl = 0, m_nwr, checks = 0, errors = 0;
    bit m_valid;

    // Memories: rdata captured by the engine on the RL-th edge after the address appears
    assign s_rdata_i   = (RL == 1) ? smem[s_addr_o] : s_pipe[RL > 1 ? RL - 2 : 0];
    assign enc_rdata_i = (RL == 1) ? enc_mem[enc_addr_o] : e_pipe[RL > 1 ? RL - 2 : 0];

    always @(posedge clk) begin
        if (ld) begin
            smem <= s_init;
            for (int a = 0; a < 16; a++) dec_mem[a] <= '0;
            nwr <= 0;
            ndone <= 0;
            nbusy <= 0;
        end else begin
            if (s_wen_o) smem[s_addr_o] <= s_wdata_o;
            if (dec_wen_o) begin
                dec_mem[dec_addr_o] <= dec_wdata_o;
                nwr <= nwr + 1;
            end
            if (done_o) ndone <= ndone + 1;
            if (busy_o) nbusy <= nbusy + 1;
        end
        if (s_wen_o && dec_wen_o) novl <= novl + 1;
        s_pipe[0] <= smem[s_addr_o];
        e_pipe[0] <= enc_mem[enc_addr_o];
        for (int p = 1; p < RL; p++) begin
            s_pipe[p] <= s_pipe[p-1];
            e_pipe[p] <= e_pipe[p-1];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ksa(input logic [63:0] key, input int klen);
        int j = 0;
        logic [7:0] t;
        for (int i = 0; i < 256; i++) s_init[i] = 8'(i);
        if (klen > 0)
            for (int i = 0; i < 256; i++) begin
                j = (j + s_init[i] + key[8*(klen-1-(i%klen)) +: 8]) % 256;
                t = s_init[i];
                s_init[i] = s_init[j];
                s_init[j] = t;
            end
    endtask

    // Textbook RC4 keystream applied to enc_mem, starting from s_init
    task automatic model_run(input bit use_chk);
        int i = 0, j = 0;
        logic [7:0] t, b;
        m_s = s_init;
        m_nwr = 0;
        m_valid = 1'b1;
        for (int k = 0; k < ML; k++) begin
            i = (i + 1) % 256;
            j = (j + m_s[i]) % 256;
            t = m_s[i];
            m_s[i] = m_s[j];
            m_s[j] = t;
            b = m_s[(m_s[i] + m_s[j]) % 256] ^ enc_mem[k];
            m_dec[k] = b;
            m_nwr++;
            if (use_chk && !((b >= 8'h61 && b <= 8'h7A) || b == 8'h20)) begin
                m_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic lowercase_msg();
        for (int k = 0; k < 16; k++) enc_mem[k] = '0;
        model_run(1'b0);
        for (int k = 0; k < ML; k++)
            enc_mem[k] = m_dec[k] ^ (($urandom_range(5, 0) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(25, 0)));
    endtask

    task automatic load();
        ld = 1'b1;
        @(posedge clk);
        #1 ld = 1'b0;
    endtask

    task automatic run(input bit dup);
        int c = 0;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        while (ndone == 0 && c < 5000) begin
            c++;
            start_i = dup && (c == 10 || c == 40);
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        if (c >= 5000) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done after %0d cycles", c);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic verify(input string nm);
        int diff = 0;
        chk({nm, "_valid"}, valid_o, m_valid);
        chk({nm, "_writes"}, nwr, m_nwr);
        chk({nm, "_done_pulses"}, ndone, 1);
        chk({nm, "_busy_cycles"}, nbusy, m_nwr * BC);
        for (int k = 0; k < m_nwr; k++) chk($sformatf("%s_dec%0d", nm, k), dec_mem[k], m_dec[k]);
        for (int a = 0; a < 256; a++) diff += (smem[a] != m_s[a]) ? 1 : 0;
        chk({nm, "_sbox_diffs"}, diff, 0);
    endtask

    typedef struct {
        logic [63:0]   key;
        int            klen;
        logic [ML*8-1:0] enc;
        logic [ML*8-1:0] exp;
        int            chk_nwr;
    } vec_t;

    vec_t tv [4];

    initial begin
        tv[0] = '{64'h0, 0, 72'h0, 72'h0205070D0D171F2828, 1};
        tv[1] = '{64'h4B6579, 3, 72'hBBF316E8D940AF0AD3, 72'h506C61696E74657874, 1};
        tv[2] = '{64'h536563726574, 6, 72'h45A01F645FC35B3835, 72'h41747461636B206174, 1};
        tv[3] = '{64'h0, 0, 72'h630000000000000000, 72'h6105070D0D171F2828, 2};
        reset_n = 1'b0;
        start_i = 1'b0;
        ld = 1'b0;
        for (int k = 0; k < 16; k++) enc_mem[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_wens", {s_wen_o, dec_wen_o}, 0);
        chk("rst_addrs", {s_addr_o, enc_addr_o, dec_addr_o}, 0);
        chk("rst_wdata", {s_wdata_o, dec_wdata_o}, 0);
        reset_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            int en;
            ksa(tv[v].key, tv[v].klen);
            for (int k = 0; k < ML; k++) enc_mem[k] = tv[v].enc[8*(ML-1-k) +: 8];
            model_run(CHK);
            load();
            run(1'b0);
            en = CHK ? tv[v].chk_nwr : ML;
            chk($sformatf("tv%0d_writes", v), nwr, en);
            chk($sformatf("tv%0d_valid", v), valid_o, CHK ? 0 : 1);
            for (int k = 0; k < en; k++)
                chk($sformatf("tv%0d_byte%0d", v, k), dec_mem[k], tv[v].exp[8*(ML-1-k) +: 8]);
            verify($sformatf("tv%0d", v));
        end

        for (int r = 0; r < 10; r++) begin
            logic [7:0] t;
            int x;
            for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
            for (int a = 255; a > 0; a--) begin
                x = $urandom_range(a, 0);
                t = s_init[a];
                s_init[a] = s_init[x];
                s_init[x] = t;
            end
            if (r % 3 == 0) for (int k = 0; k < ML; k++) enc_mem[k] = 8'($urandom);
            else lowercase_msg();
            model_run(CHK);
            load();
            run(r == 4);
            verify($sformatf("rnd%0d", r));
            repeat (5) @(posedge clk);
            #1 chk($sformatf("rnd%0d_valid_held", r), valid_o, m_valid);
        end

        // Reset while byte 2 is in WR_SI, then a clean restart
        ksa(64'h4B6579, 3);
        lowercase_msg();
        load();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 0; c < 2000 && !(nwr == 2 && s_wen_o); c++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid_reached", {nwr[3:0], s_wen_o}, {4'd2, 1'b1});
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_wens", {s_wen_o, dec_wen_o}, 0);
        chk("rst_mid_done_valid", {done_o, valid_o}, 0);
        reset_n = 1'b1;
        model_run(CHK);
        load();
        run(1'b0);
        verify("restart");

        // start pulsed while busy must not restart the message
        ksa(64'h536563726574, 6);
        lowercase_msg();
        model_run(CHK);
        load();
        run(1'b1);
        verify("dup_start");

        chk("wen_overlap", novl, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
